act_skew_feeder: RTL and testbench

ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

---
 rtl/tpu_pkg.sv | 19 +
 rtl/vec_fifo.sv | 54 +++++
 rtl/act_skew_feeder.sv | 124 ++++++++++++
 tb/tb_act_skew_feeder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array front end: default sizing,
// feeder state encoding and small arithmetic helpers.
package tpu_pkg;

  localparam int DEF_LANES      = 4;
  localparam int DEF_DW         = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feed_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// Synchronous FIFO with registered occupancy and a combinational head read.
// Writes while full and reads while empty are ignored.
module vec_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking '<=' so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and feeds them to the systolic rows with a
// per-lane diagonal skew; tracks matrix boundaries and pulses done at the end.
module act_skew_feeder
  import tpu_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [LANES*DW-1:0] ain,
  output logic [LANES-1:0]    dv_ain,
  output logic                busy,
  output logic                done,
  output logic [15:0]         vec_count
);

  localparam int VW = LANES * DW;
  localparam int CW = $clog2(LANES + 1);

  feed_state_e      state;
  logic [CW-1:0]    drain_cnt;
  logic [VW:0]      head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             head_last;
  logic [LANES-1:0] lane_busy;
  logic [LANES-1:0] last_q;

  assign s_ready   = !fifo_full;
  assign pop       = !fifo_empty && (state != ST_DRAIN);
  assign head_last = head[VW];

  vec_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_vec_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_valid),
    .wr_data ({s_last, s_data}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // DRAIN holds off pops until the last vector has left every lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_STREAM: begin
          if (pop) begin
            if (head_last) begin
              state     <= ST_DRAIN;
              drain_cnt <= CW'(LANES);
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == CW'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane i sees i+1 stages; a non-pop cycle shifts in a zero bubble.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] d_q [i+1];
    logic [i:0]    v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) d_q[j] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= pop ? head[i*DW +: DW] : '0;
        v_q[0] <= pop;
        for (int j = 1; j <= i; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign ain[i*DW +: DW] = d_q[i];
    assign dv_ain[i]       = v_q[i];
    assign lane_busy[i]    = |v_q;
  end

  // The last flag rides alongside the deepest lane so done lines up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else begin
      last_q[0] <= pop && head_last;
      for (int j = 1; j < LANES; j++) last_q[j] <= last_q[j-1];
    end
  end

  assign done = last_q[LANES-1];

  always_ff @(posedge clk) begin
    if (rst)      vec_count <= '0;
    else if (done) vec_count <= '0;
    else if (pop)  vec_count <= sat_inc16(vec_count);
  end

  assign busy = (state != ST_IDLE) || !fifo_empty || (|lane_busy);

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench: directed scenarios plus random traffic compared
// cycle by cycle against a timing-rule reference model.
module tb_act_skew_feeder;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int VW    = LANES * DW;
  localparam int NCYC  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic [VW-1:0]     s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [VW-1:0]     ain;
  logic [LANES-1:0]  dv_ain;
  logic              busy;
  logic              done;
  logic [15:0]       vec_count;

  act_skew_feeder #(
    .LANES      (LANES),
    .DW         (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .ain       (ain),
    .dv_ain    (dv_ain),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted vectors plus per-cycle expected outputs.
  logic [VW:0]   mq [$];
  logic [DW-1:0] e_ain  [NCYC][LANES];
  bit            e_dv   [NCYC][LANES];
  bit            e_done [NCYC];
  int            n;
  int            drain_until;
  int            last_pop;
  bit            in_mat;
  int            m_cnt;
  int            n_checks;
  int            n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int c = 0; c < NCYC; c++) begin
      e_done[c] = 1'b0;
      for (int l = 0; l < LANES; l++) begin
        e_ain[c][l] = '0;
        e_dv[c][l]  = 1'b0;
      end
    end
    drain_until = -1;
    last_pop    = -100;
    in_mat      = 1'b0;
    m_cnt       = 0;
  endtask

  task automatic compare();
    logic [VW-1:0]    ea;
    logic [LANES-1:0] ed;
    bit               eb;
    for (int l = 0; l < LANES; l++) begin
      ea[l*DW +: DW] = e_ain[n][l];
      ed[l]          = e_dv[n][l];
    end
    eb = in_mat || (mq.size() != 0) || (n > last_pop && n <= last_pop + LANES);
    check("s_ready",   64'(s_ready),   64'(mq.size() < DEPTH));
    check("ain",       64'(ain),       64'(ea));
    check("dv_ain",    64'(dv_ain),    64'(ed));
    check("done",      64'(done),      64'(e_done[n]));
    check("busy",      64'(busy),      64'(eb));
    check("vec_count", 64'(vec_count), 64'(m_cnt));
  endtask

  task automatic step(input bit v, input logic [VW-1:0] d, input bit l, input bit r);
    bit          do_pop;
    bit          do_push;
    logic [VW:0] e;
    compare();
    rst     = r;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    if (r) begin
      model_reset();
    end else begin
      do_pop  = (mq.size() != 0) && !(n <= drain_until);
      do_push = v && (mq.size() < DEPTH);
      if (e_done[n])   m_cnt = 0;
      else if (do_pop) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
      if (n == drain_until) in_mat = 1'b0;
      if (do_pop) begin
        e        = mq.pop_front();
        last_pop = n;
        in_mat   = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          e_ain[n+1+k][k] = e[k*DW +: DW];
          e_dv[n+1+k][k]  = 1'b1;
        end
        if (e[VW]) begin
          e_done[n+LANES] = 1'b1;
          drain_until     = n + LANES;
        end
      end
      if (do_push) mq.push_back({l, d});
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n        = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // Reset state, then a single one-vector matrix.
    idle(2);
    step(1'b1, 32'h04030201, 1'b1, 1'b0);
    idle(8);

    // Three back-to-back vectors forming one matrix.
    step(1'b1, 32'hA3A2A1A0, 1'b0, 1'b0);
    step(1'b1, 32'hB3B2B1B0, 1'b0, 1'b0);
    step(1'b1, 32'hC3C2C1C0, 1'b1, 1'b0);
    idle(10);

    // Fill the FIFO while draining; later vectors start the next matrix.
    step(1'b1, 32'h0F0E0D0C, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      step(1'b1, 32'h10000000 + 32'(k), (k == 3), 1'b0);
    idle(24);

    // Gap of two idle cycles inside a matrix.
    step(1'b1, 32'h55443322, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 32'h99887766, 1'b1, 1'b0);
    idle(10);

    // Reset while draining discards everything, no done.
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(6);

    // Random traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 2) != 0), VW'($urandom()),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
